// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is registered read.
module sync_fifo_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = (2 ** DEPTH_LOG2) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic                  rdempty,
  output logic                  wrfull,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_check
    $error("sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_check
    $error("sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] w_ptr;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  rd_accept;
  logic                  wr_accept;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // when it is also being read.
  assign rd_accept = rdreq && !rdempty;
  assign wr_accept = wrreq && (!wrfull || rd_accept);

  always_comb begin
    count_nxt = count;
    if (wr_accept && !rd_accept)
      count_nxt = count + CW'(1);
    else if (rd_accept && !wr_accept)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (clrn && wr_accept)
      mem[w_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      rdempty      <= 1'b1;
      wrfull       <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_accept) w_ptr <= w_ptr + DEPTH_LOG2'(1);
      if (rd_accept) r_ptr <= r_ptr + DEPTH_LOG2'(1);
      count        <= count_nxt;
      rdempty      <= (count_nxt == '0);
      wrfull       <= (count_nxt == DEPTH_C);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      // A fresh error event wins over a coincident clear.
      if (wrreq && wrfull && !rd_accept) overflow <= 1'b1;
      else if (clr_err)                  overflow <= 1'b0;
      if (rdreq && rdempty)              underflow <= 1'b1;
      else if (clr_err)                  underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  always_comb begin
    q       = rdempty ? '0 : mem[r_ptr];
    q_valid = !rdempty;
  end
`else
  logic [WIDTH-1:0] q_reg;
  logic             q_valid_reg;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
    end else begin
      if (rd_accept) q_reg <= mem[r_ptr];
      q_valid_reg <= rd_accept;
    end
  end

  always_comb begin
    q       = q_reg;
    q_valid = q_valid_reg;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=8, AF=6, AE=2): directed table,
// FWFT corner sequence when SYNC_FIFO_FWFT_EN is defined, then randomized traffic vs a queue model.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int DL = 3;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic [W-1:0]  data = '0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  q;
  logic          q_valid, rdempty, wrfull, almost_full, almost_empty;
  logic [DL:0]   count;
  logic          overflow, underflow;

  sync_fifo_param #(.WIDTH(W), .DEPTH_LOG2(DL), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .clrn(clrn), .data(data), .wrreq(wrreq), .rdreq(rdreq), .clr_err(clr_err),
    .q(q), .q_valid(q_valid), .rdempty(rdempty), .wrfull(wrfull),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Reference model: a queue of stored words plus the visible read-side state.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_q = '0;
  logic         m_qv = 1'b0;
  logic         m_ov = 1'b0;
  logic         m_un = 1'b0;

  typedef struct {
    logic         rst;
    logic         wr;
    logic         rd;
    logic         clr;
    logic [W-1:0] d;
    int unsigned  cnt;
    logic [W-1:0] eq;
    logic         eqv;
    logic         eov;
    logic         eun;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic rst, wr, rd, clr, input logic [W-1:0] d,
                              input int unsigned cnt, input logic [W-1:0] eq,
                              input logic eqv, eov, eun);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.clr = clr; v.d = d;
    v.cnt = cnt; v.eq = eq; v.eqv = eqv; v.eov = eov; v.eun = eun;
    vt.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_edge(input logic rst, wr, rd, clr, input logic [W-1:0] d);
    int unsigned n;
    logic rd_ok, wr_ok;
    if (rst) begin
      mq.delete();
      m_q = '0; m_qv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      n = mq.size();
      rd_ok = rd && (n > 0);
      wr_ok = wr && ((n < D) || rd_ok);
      if (wr && (n == D) && !rd_ok) m_ov = 1'b1;
      else if (clr)                 m_ov = 1'b0;
      if (rd && (n == 0))           m_un = 1'b1;
      else if (clr)                 m_un = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      m_qv = rd_ok;
      if (rd_ok) m_q = mq[0];
`endif
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back(d);
    end
`ifdef SYNC_FIFO_FWFT_EN
    m_qv = (mq.size() > 0);
    m_q  = (mq.size() > 0) ? mq[0] : '0;
`endif
  endfunction

  task automatic check_model();
    int unsigned n;
    n = mq.size();
    chk("count",        32'(count),        32'(n));
    chk("rdempty",      32'(rdempty),      32'(n == 0));
    chk("wrfull",       32'(wrfull),       32'(n == D));
    chk("almost_full",  32'(almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("overflow",     32'(overflow),     32'(m_ov));
    chk("underflow",    32'(underflow),    32'(m_un));
    chk("q_valid",      32'(q_valid),      32'(m_qv));
    chk("q",            32'(q),            32'(m_q));
  endtask

  task automatic step(input logic rst, wr, rd, clr, input logic [W-1:0] d);
    clrn = !rst; wrreq = wr; rdreq = rd; clr_err = clr; data = d;
    @(posedge clk);
    model_edge(rst, wr, rd, clr, d);
    #1;
    check_model();
  endtask

  initial begin
    logic [W-1:0] drain [8];
    logic [W-1:0] held;
    int unsigned  wb, rb;

    drain[0] = 8'h16; drain[1] = 8'h17; drain[2] = 8'h18;
    for (int unsigned i = 0; i < 5; i++) drain[3+i] = 8'(8'hA0 + i);

    // rst wr rd clr data | count q q_valid overflow underflow
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int unsigned i = 0; i < 8; i++) add(0, 1, 0, 0, 8'(8'h11 + i), i + 1, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 8'h99, 8, 8'h00, 0, 1, 0);
    add(0, 0, 0, 1, 8'h00, 8, 8'h00, 0, 0, 0);
    for (int unsigned i = 0; i < 8; i++) add(0, 0, 1, 0, 8'h00, 7 - i, 8'(8'h11 + i), 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h18, 0, 0, 0);
    for (int unsigned i = 0; i < 8; i++) add(0, 1, 0, 0, 8'(8'h11 + i), i + 1, 8'h18, 0, 0, 0);
    for (int unsigned i = 0; i < 5; i++) add(0, 1, 1, 0, 8'(8'hA0 + i), 8, 8'(8'h11 + i), 1, 0, 0);
    for (int unsigned i = 0; i < 8; i++) add(0, 0, 1, 0, 8'h00, 7 - i, drain[i], 1, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'hA4, 0, 0, 1);
    add(0, 0, 0, 1, 8'h00, 0, 8'hA4, 0, 0, 0);
    add(0, 0, 1, 1, 8'h00, 0, 8'hA4, 0, 0, 1);
    add(0, 0, 0, 1, 8'h00, 0, 8'hA4, 0, 0, 0);
    add(0, 1, 1, 0, 8'h42, 1, 8'hA4, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 8'h42, 1, 0, 1);
    add(0, 0, 0, 1, 8'h00, 0, 8'h42, 0, 0, 0);
    for (int unsigned i = 0; i < 3; i++) add(0, 1, 0, 0, 8'(8'h01 + i), i + 1, 8'h42, 0, 0, 0);
    add(1, 1, 0, 0, 8'h77, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 8'h5A, 1, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h5A, 1, 0, 0);

`ifndef SYNC_FIFO_FWFT_EN
    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].wr, vt[i].rd, vt[i].clr, vt[i].d);
      chk("vec_count",     32'(count),     32'(vt[i].cnt));
      chk("vec_q",         32'(q),         32'(vt[i].eq));
      chk("vec_q_valid",   32'(q_valid),   32'(vt[i].eqv));
      chk("vec_overflow",  32'(overflow),  32'(vt[i].eov));
      chk("vec_underflow", 32'(underflow), 32'(vt[i].eun));
    end
    // Rejected read must leave q holding its last popped word.
    held = q;
    step(0, 0, 1, 0, 8'h00);
    chk("hold_q_on_underflow", 32'(q), 32'(held));
    chk("hold_q_valid_low",    32'(q_valid), 32'(0));
`else
    step(1, 0, 0, 0, 8'h00);
    chk("fwft_reset_q", 32'(q), 32'(0));
    step(0, 1, 0, 0, 8'h3C);
    chk("fwft_q",       32'(q), 32'(8'h3C));
    chk("fwft_q_valid", 32'(q_valid), 32'(1));
    step(0, 0, 0, 0, 8'h00);
    chk("fwft_q_hold",  32'(q), 32'(8'h3C));
    step(0, 0, 1, 0, 8'h00);
    chk("fwft_rdempty", 32'(rdempty), 32'(1));
    chk("fwft_q_valid_low", 32'(q_valid), 32'(0));
    step(0, 1, 1, 0, 8'h5D);
    chk("fwft_both_empty_q", 32'(q), 32'(8'h5D));
    chk("fwft_both_empty_un", 32'(underflow), 32'(1));
    step(0, 0, 0, 1, 8'h00);
`endif

    // Randomized traffic with shifting write/read bias to visit full and empty often.
    for (int unsigned blk = 0; blk < 8; blk++) begin
      wb = (blk % 2 == 0) ? 80 : 30;
      rb = (blk % 2 == 0) ? 30 : 80;
      for (int unsigned c = 0; c < 100; c++) begin
        step(($urandom_range(0, 149) == 0),
             ($urandom_range(0, 99) < wb),
             ($urandom_range(0, 99) < rb),
             ($urandom_range(0, 9) == 0),
             8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
